regress_monitor: RTL and testbench
==================================

# regress_monitor

Synthesizable, parametrised self-checking monitor for processor regression runs. Snoops the CPU data bus and keeps a shadow of the last value written to each configured check address. It detects end-of-program (self-jump halt loop) or a cycle timeout, then issues a registered PASS/FAIL verdict with a failure code. It sits beside `top` in directed suites, replacing per-test hand-written end-of-run memory asserts with one checker that handles N locations.

## Interface
Parameters:
- ADDR_WIDTH, 16, bus address width
- DATA_WIDTH, 8, bus data width
- NUM_CHECKS, 4, expectation table entries (1..16)
- TIMEOUT_CYCLES, 150, RUN cycles before timeout verdict (≥2)
- HALT_REPEAT, 2, consecutive opcode fetches from one address that count as halt (≥2)
- CNT_WIDTH, 16, cycle counter width

Ports:
- ph2  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high
- cfg_we  in  1  write expectation entry
- cfg_idx  in  $clog2(NUM_CHECKS) (min 1)  entry index
- cfg_addr  in  ADDR_WIDTH  expected address
- cfg_data  in  DATA_WIDTH  expected final value
- cfg_valid  in  1  entry enable written with entry
- start  in  1  begin run (pulse)
- bus_addr  in  ADDR_WIDTH  CPU address
- bus_wdata  in  DATA_WIDTH  CPU write data
- bus_we  in  1  write strobe, one per write
- bus_fetch  in  1  opcode-fetch strobe
- done  out  1  verdict valid
- pass  out  1  run passed
- fail  out  1  run failed
- fail_code  out  2  0 none, 1 value mismatch/unwritten, 2 timeout, 3 empty table
- written_mask  out  NUM_CHECKS  entries written at least once this run
- cycle_count  out  CNT_WIDTH  RUN cycles elapsed, saturating
- fail_idx  out  cfg_idx width  lowest failing entry (trace build only)
- fail_data  out  DATA_WIDTH  shadow value of fail_idx (trace build only)

## Operation
- States: IDLE, RUN, DONE. Reset -> IDLE; table valid bits, shadows, written_mask, counters, all outputs 0.
- cfg_we accepted in IDLE and DONE; ignored in RUN. Table survives re-runs.
- start in IDLE/DONE -> RUN next edge; clears shadows, written_mask, cycle_count, halt tracker, done/pass/fail/fail_code. start in RUN ignored.
- RUN: for every valid entry with cfg_addr == bus_addr while bus_we=1, shadow <= bus_wdata and written bit set. Duplicate addresses update all matching entries.
- Halt tracker: on bus_fetch, same address as last fetch -> rep_cnt+1, else rep_cnt <= 1 and last address latched. Halt event when rep_cnt reaches HALT_REPEAT.
- Timeout event when cycle_count == TIMEOUT_CYCLES-1 with no halt event that cycle. Halt wins a tie.
- Verdict on halt: no valid entries -> code 3; any valid entry unwritten or shadow ≠ cfg_data -> code 1; else pass. Timeout -> code 2 regardless of shadows.
- DONE: done=1 and exactly one of pass/fail = 1, held until start or reset. Bus ignored.

## Timing
- Bus write and halt event in the same cycle: write included in the verdict.
- Verdict registered: done/pass/fail visible one cycle after the end-event edge. Minimum RUN-to-done latency is HALT_REPEAT fetch cycles plus 1.
- cycle_count increments every RUN cycle, freezes in DONE, saturates at all-ones.
- Reset asserted mid-run: immediate (asynchronous) return to IDLE with all outputs 0. Table cleared.
- start and cfg_we in the same DONE cycle: table write takes effect, and the new run uses the new entry.

## Configuration
- REGRESS_MONITOR_TRACE_EN defined: fail_idx/fail_data captured at the verdict for the lowest-index failing valid entry. They hold 0 on pass, code 2, or code 3. They clear on start/reset.
- Undefined: fail_idx and fail_data tied to 0; capture logic absent. All other behaviour is identical.

## Test plan
- Entry0 = {0x0042, 0xA5, valid}. Run, write 0x42<-0xA5, then two fetches at 0xF010 -> done=1, pass=1, fail_code=0 one cycle later.
- Same config, write 0x42<-0xA5 then 0x42<-0x5A, then halt -> fail=1, fail_code=1; trace build: fail_idx=0, fail_data=0x5A.
- Entry0 valid, no write to 0x42 before halt -> fail_code=1, written_mask=0.
- TIMEOUT_CYCLES=20, never halt -> done at cycle 20, fail_code=2, cycle_count=19.
- All entries invalid, halt -> fail_code=3. Then load entry1 {0x0010,0x01}, start, write 0x10<-0x01, halt -> pass. Entry table retained across runs.
- Reset asserted mid-RUN after two matching writes -> done=pass=fail=0, written_mask=0 immediately. Next run without reloading the table -> fail_code=3.

Source files
------------

// File: rtl/regress_monitor.sv
// Regression checker: shadows bus writes to N expected addresses, ends a run on a self-jump halt or timeout, registers a PASS/FAIL verdict.
// Optional REGRESS_MONITOR_TRACE_EN captures the lowest failing entry index and its shadow value.
module regress_monitor #(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 8,
    parameter int NUM_CHECKS     = 4,
    parameter int TIMEOUT_CYCLES = 150,
    parameter int HALT_REPEAT    = 2,
    parameter int CNT_WIDTH      = 16,
    localparam int IDX_W         = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1
) (
    input  logic                  ph2,
    input  logic                  reset,
    input  logic                  cfg_we,
    input  logic [IDX_W-1:0]      cfg_idx,
    input  logic [ADDR_WIDTH-1:0] cfg_addr,
    input  logic [DATA_WIDTH-1:0] cfg_data,
    input  logic                  cfg_valid,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] bus_addr,
    input  logic [DATA_WIDTH-1:0] bus_wdata,
    input  logic                  bus_we,
    input  logic                  bus_fetch,
    output logic                  done,
    output logic                  pass,
    output logic                  fail,
    output logic [1:0]            fail_code,
    output logic [NUM_CHECKS-1:0] written_mask,
    output logic [CNT_WIDTH-1:0]  cycle_count,
    output logic [IDX_W-1:0]      fail_idx,
    output logic [DATA_WIDTH-1:0] fail_data
);
    localparam int RC_W = $clog2(HALT_REPEAT + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                                 state_q, state_d;
    logic [NUM_CHECKS-1:0][ADDR_WIDTH-1:0]  tbl_addr_q, tbl_addr_d;
    logic [NUM_CHECKS-1:0][DATA_WIDTH-1:0]  tbl_data_q, tbl_data_d;
    logic [NUM_CHECKS-1:0]                  tbl_vld_q, tbl_vld_d;
    logic [NUM_CHECKS-1:0][DATA_WIDTH-1:0]  shadow_q, shadow_d;
    logic [NUM_CHECKS-1:0]                  written_q, written_d;
    logic [ADDR_WIDTH-1:0]                  last_addr_q, last_addr_d;
    logic [RC_W-1:0]                        rep_cnt_q, rep_cnt_d;
    logic [CNT_WIDTH-1:0]                   cyc_cnt_q, cyc_cnt_d;
    logic                                   done_q, done_d;
    logic                                   pass_q, pass_d;
    logic                                   fail_q, fail_d;
    logic [1:0]                             code_q, code_d;
    logic                                   halt_evt, tout_evt, any_vld, any_bad;
`ifdef REGRESS_MONITOR_TRACE_EN
    logic [IDX_W-1:0]                       fidx_q, fidx_d, bad_idx;
    logic [DATA_WIDTH-1:0]                  fdata_q, fdata_d, bad_dat;
`endif

    always_comb begin
        state_d     = state_q;
        tbl_addr_d  = tbl_addr_q;
        tbl_data_d  = tbl_data_q;
        tbl_vld_d   = tbl_vld_q;
        shadow_d    = shadow_q;
        written_d   = written_q;
        last_addr_d = last_addr_q;
        rep_cnt_d   = rep_cnt_q;
        cyc_cnt_d   = cyc_cnt_q;
        done_d      = done_q;
        pass_d      = pass_q;
        fail_d      = fail_q;
        code_d      = code_q;
        halt_evt    = 1'b0;
        tout_evt    = 1'b0;
        any_vld     = 1'b0;
        any_bad     = 1'b0;
`ifdef REGRESS_MONITOR_TRACE_EN
        fidx_d      = fidx_q;
        fdata_d     = fdata_q;
        bad_idx     = '0;
        bad_dat     = '0;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (cfg_we && (32'(cfg_idx) < NUM_CHECKS)) begin
                    tbl_addr_d[cfg_idx] = cfg_addr;
                    tbl_data_d[cfg_idx] = cfg_data;
                    tbl_vld_d[cfg_idx]  = cfg_valid;
                end
                if (start) begin
                    state_d     = S_RUN;
                    shadow_d    = '0;
                    written_d   = '0;
                    last_addr_d = '0;
                    rep_cnt_d   = '0;
                    cyc_cnt_d   = '0;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    fail_d      = 1'b0;
                    code_d      = 2'd0;
`ifdef REGRESS_MONITOR_TRACE_EN
                    fidx_d      = '0;
                    fdata_d     = '0;
`endif
                end
            end
            S_RUN: begin
                for (int i = 0; i < NUM_CHECKS; i++) begin
                    if (tbl_vld_q[i] && bus_we && (tbl_addr_q[i] == bus_addr)) begin
                        shadow_d[i]  = bus_wdata;
                        written_d[i] = 1'b1;
                    end
                end
                // rep_cnt of zero means no fetch seen yet this run
                if (bus_fetch) begin
                    if ((rep_cnt_q != '0) && (bus_addr == last_addr_q))
                        rep_cnt_d = rep_cnt_q + RC_W'(1);
                    else
                        rep_cnt_d = RC_W'(1);
                    last_addr_d = bus_addr;
                end
                halt_evt = bus_fetch && (rep_cnt_d == RC_W'(HALT_REPEAT));
                tout_evt = !halt_evt && (cyc_cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

                // Judge against the _d shadows so a write in the halt cycle counts
                for (int i = NUM_CHECKS - 1; i >= 0; i--) begin
                    if (tbl_vld_q[i]) begin
                        any_vld = 1'b1;
                        if (!written_d[i] || (shadow_d[i] != tbl_data_q[i])) begin
                            any_bad = 1'b1;
`ifdef REGRESS_MONITOR_TRACE_EN
                            bad_idx = IDX_W'(i);
                            bad_dat = shadow_d[i];
`endif
                        end
                    end
                end

                if (halt_evt || tout_evt) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    if (tout_evt) begin
                        fail_d = 1'b1;
                        code_d = 2'd2;
                    end else if (!any_vld) begin
                        fail_d = 1'b1;
                        code_d = 2'd3;
                    end else if (any_bad) begin
                        fail_d = 1'b1;
                        code_d = 2'd1;
`ifdef REGRESS_MONITOR_TRACE_EN
                        fidx_d  = bad_idx;
                        fdata_d = bad_dat;
`endif
                    end else begin
                        pass_d = 1'b1;
                    end
                end else if (cyc_cnt_q != '1) begin
                    cyc_cnt_d = cyc_cnt_q + CNT_WIDTH'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge ph2 or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            tbl_addr_q  <= '0;
            tbl_data_q  <= '0;
            tbl_vld_q   <= '0;
            shadow_q    <= '0;
            written_q   <= '0;
            last_addr_q <= '0;
            rep_cnt_q   <= '0;
            cyc_cnt_q   <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            code_q      <= 2'd0;
`ifdef REGRESS_MONITOR_TRACE_EN
            fidx_q      <= '0;
            fdata_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            tbl_addr_q  <= tbl_addr_d;
            tbl_data_q  <= tbl_data_d;
            tbl_vld_q   <= tbl_vld_d;
            shadow_q    <= shadow_d;
            written_q   <= written_d;
            last_addr_q <= last_addr_d;
            rep_cnt_q   <= rep_cnt_d;
            cyc_cnt_q   <= cyc_cnt_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            code_q      <= code_d;
`ifdef REGRESS_MONITOR_TRACE_EN
            fidx_q      <= fidx_d;
            fdata_q     <= fdata_d;
`endif
        end
    end

    assign done         = done_q;
    assign pass         = pass_q;
    assign fail         = fail_q;
    assign fail_code    = code_q;
    assign written_mask = written_q;
    assign cycle_count  = cyc_cnt_q;
`ifdef REGRESS_MONITOR_TRACE_EN
    assign fail_idx     = fidx_q;
    assign fail_data    = fdata_q;
`else
    assign fail_idx     = '0;
    assign fail_data    = '0;
`endif
endmodule

// File: tb/tb_regress_monitor.sv
// Scoreboard bench for regress_monitor: a run-level model predicts each verdict; a monitor checks it when done rises.
module tb_regress_monitor;
    localparam int AW = 16, DW = 8, NC = 4, TO = 20, HR = 2, CW = 16, IW = 2;

    logic          ph2 = 1'b0;
    logic          reset = 1'b1;
    logic          cfg_we = 1'b0;
    logic [IW-1:0] cfg_idx = '0;
    logic [AW-1:0] cfg_addr = '0;
    logic [DW-1:0] cfg_data = '0;
    logic          cfg_valid = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] bus_addr = '0;
    logic [DW-1:0] bus_wdata = '0;
    logic          bus_we = 1'b0;
    logic          bus_fetch = 1'b0;
    logic          done, pass, fail;
    logic [1:0]    fail_code;
    logic [NC-1:0] written_mask;
    logic [CW-1:0] cycle_count;
    logic [IW-1:0] fail_idx;
    logic [DW-1:0] fail_data;

    regress_monitor #(.TIMEOUT_CYCLES(TO)) dut (
        .ph2(ph2), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .cfg_valid(cfg_valid), .start(start), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_fetch(bus_fetch), .done(done),
        .pass(pass), .fail(fail), .fail_code(fail_code), .written_mask(written_mask),
        .cycle_count(cycle_count), .fail_idx(fail_idx), .fail_data(fail_data)
    );

    always #5 ph2 = ~ph2;

    typedef struct { bit we; logic [AW-1:0] addr; logic [DW-1:0] wdata; bit fetch; } cyc_t;
    typedef struct {
        logic pass, fail; logic [1:0] code; logic [NC-1:0] mask; logic [CW-1:0] cnt;
        logic [IW-1:0] fidx; logic [DW-1:0] fdata; int cyc;
    } exp_t;

    exp_t          exp_q[$];
    int            n_tests = 0, n_fail = 0, cyc = 0;
    logic [AW-1:0] m_addr[NC];
    logic [DW-1:0] m_data[NC];
    bit            m_vld[NC];
    logic          done_prev = 1'b0;

    always @(posedge ph2) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge ph2);
        #1;
    endtask

    function automatic cyc_t mk(bit we, int a, int d, bit f);
        cyc_t c;
        c.we = we; c.addr = AW'(a); c.wdata = DW'(d); c.fetch = f;
        return c;
    endfunction

    task automatic cfg_load(input int idx, input int a, input int d, input bit v);
        cfg_we = 1'b1; cfg_idx = IW'(idx); cfg_addr = AW'(a); cfg_data = DW'(d); cfg_valid = v;
        tick();
        cfg_we = 1'b0;
        m_addr[idx] = AW'(a); m_data[idx] = DW'(d); m_vld[idx] = v;
    endtask

    // Executes one run; the model works at run level: a last-value map per address and the fetch history.
    task automatic run_seq(input cyc_t seq[$], input bit pc_en, input int pc_idx,
                           input int pc_a, input int pc_d, input bit pc_v);
        int            mem[int];
        logic [AW-1:0] fetches[$];
        exp_t          e;
        cyc_t          c;
        bit            halt, tout, any_v;
        int            i, bad;
        if (pc_en) begin
            cfg_we = 1'b1; cfg_idx = IW'(pc_idx); cfg_addr = AW'(pc_a);
            cfg_data = DW'(pc_d); cfg_valid = pc_v;
            m_addr[pc_idx] = AW'(pc_a); m_data[pc_idx] = DW'(pc_d); m_vld[pc_idx] = pc_v;
        end
        start = 1'b1;
        tick();
        start = 1'b0; cfg_we = 1'b0;
        i = 0;
        forever begin
            c = (i < seq.size()) ? seq[i] : mk(0, 0, 0, 0);
            bus_we = c.we; bus_addr = c.addr; bus_wdata = c.wdata; bus_fetch = c.fetch;
            if (c.we) mem[int'(c.addr)] = int'(c.wdata);
            halt = 1'b0;
            if (c.fetch) begin
                fetches.push_back(c.addr);
                if (fetches.size() >= HR) begin
                    halt = 1'b1;
                    for (int k = 0; k < HR; k++)
                        if (fetches[fetches.size() - 1 - k] != c.addr) halt = 1'b0;
                end
            end
            tout = !halt && (i == TO - 1);
            if (halt || tout) break;
            tick();
            i++;
        end
        e.cyc = cyc + 1; e.cnt = CW'(i); e.mask = '0; e.fidx = '0; e.fdata = '0;
        e.pass = 1'b0; e.fail = 1'b1; any_v = 1'b0; bad = -1;
        for (int k = 0; k < NC; k++) begin
            if (m_vld[k]) begin
                any_v = 1'b1;
                if (mem.exists(int'(m_addr[k]))) e.mask[k] = 1'b1;
                if (bad < 0 && (!mem.exists(int'(m_addr[k])) || mem[int'(m_addr[k])] != int'(m_data[k])))
                    bad = k;
            end
        end
        if (tout) e.code = 2'd2;
        else if (!any_v) e.code = 2'd3;
        else if (bad >= 0) begin
            e.code = 2'd1;
`ifdef REGRESS_MONITOR_TRACE_EN
            e.fidx = IW'(bad);
            e.fdata = mem.exists(int'(m_addr[bad])) ? DW'(mem[int'(m_addr[bad])]) : '0;
`endif
        end else begin
            e.code = 2'd0; e.pass = 1'b1; e.fail = 1'b0;
        end
        exp_q.push_back(e);
        tick();
        bus_we = 1'b0; bus_fetch = 1'b0; bus_addr = '0; bus_wdata = '0;
        for (int w = 0; w < 8 && exp_q.size() != 0; w++) tick();
        if (exp_q.size() != 0) begin
            chk("done_missing", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    // Monitor: checks the verdict at each rising edge of done.
    always @(negedge ph2) begin
        if (reset) begin
            done_prev = 1'b0;
        end else begin
            if (done && !done_prev) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_done", done, 1'b0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("latency", cyc, e.cyc);
                    chk("pass", pass, e.pass);
                    chk("fail", fail, e.fail);
                    chk("fail_code", fail_code, e.code);
                    chk("written_mask", written_mask, e.mask);
                    chk("cycle_count", cycle_count, e.cnt);
                    chk("fail_idx", fail_idx, e.fidx);
                    chk("fail_data", fail_data, e.fdata);
                end
            end
            done_prev = done;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc_t s[$];
        for (int k = 0; k < NC; k++) begin m_addr[k] = '0; m_data[k] = '0; m_vld[k] = 1'b0; end
        tick(); tick();
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_fail", fail, 0);
        chk("rst_code", fail_code, 0);
        chk("rst_mask", written_mask, 0);
        chk("rst_count", cycle_count, 0);
        chk("rst_fidx", fail_idx, 0);
        chk("rst_fdata", fail_data, 0);
        reset = 1'b0;
        tick();

        cfg_load(0, 16'h0042, 8'hA5, 1'b1);
        s = {mk(1, 16'h42, 8'hA5, 0), mk(0, 16'hF010, 0, 1), mk(0, 16'hF010, 0, 1)};
        run_seq(s, 0, 0, 0, 0, 0);
        s = {mk(1, 16'h42, 8'hA5, 0), mk(1, 16'h42, 8'h5A, 0), mk(0, 16'hF010, 0, 1), mk(0, 16'hF010, 0, 1)};
        run_seq(s, 0, 0, 0, 0, 0);
        s = {mk(0, 16'hF010, 0, 1), mk(0, 16'hF010, 0, 1)};
        run_seq(s, 0, 0, 0, 0, 0);
        s = {};
        run_seq(s, 0, 0, 0, 0, 0);

        cfg_load(0, 16'h0042, 8'hA5, 1'b0);
        s = {mk(0, 16'hF010, 0, 1), mk(0, 16'hF010, 0, 1)};
        run_seq(s, 0, 0, 0, 0, 0);
        s = {mk(1, 16'h10, 8'h01, 0), mk(0, 16'hF010, 0, 1), mk(0, 16'hF010, 0, 1)};
        run_seq(s, 1, 1, 16'h0010, 8'h01, 1'b1);
        run_seq(s, 0, 0, 0, 0, 0);
        // write coinciding with the halting fetch, non-adjacent fetches
        s = {mk(0, 16'h10, 0, 1), mk(0, 0, 0, 0), mk(1, 16'h10, 8'h01, 1)};
        run_seq(s, 0, 0, 0, 0, 0);

        start = 1'b1; tick(); start = 1'b0;
        bus_we = 1'b1; bus_addr = 16'h0010; bus_wdata = 8'h01; tick(); tick();
        bus_we = 1'b0; bus_addr = '0; bus_wdata = '0;
        chk("mask_pre_reset", written_mask, 4'b0010);
        #3 reset = 1'b1;
        #1;
        chk("mid_rst_done", done, 0);
        chk("mid_rst_pass", pass, 0);
        chk("mid_rst_fail", fail, 0);
        chk("mid_rst_mask", written_mask, 0);
        chk("mid_rst_count", cycle_count, 0);
        for (int k = 0; k < NC; k++) m_vld[k] = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        s = {mk(0, 16'hF010, 0, 1), mk(0, 16'hF010, 0, 1)};
        run_seq(s, 0, 0, 0, 0, 0);

        for (int r = 0; r < 40; r++) begin
            int len;
            if ($urandom_range(0, 2) == 0)
                for (int k = 0; k < NC; k++)
                    cfg_load(k, 16'h40 + $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 3) != 0);
            s = {};
            len = $urandom_range(2, 24);
            for (int j = 0; j < len; j++) begin
                case ($urandom_range(0, 3))
                    0: s.push_back(mk(0, 0, 0, 0));
                    1: s.push_back(mk(1, 16'h40 + $urandom_range(0, 4), $urandom_range(0, 2), 0));
                    2: s.push_back(mk(0, 16'hF000 + $urandom_range(0, 1), 0, 1));
                    default: s.push_back(mk(1, 16'h40 + $urandom_range(0, 4), $urandom_range(0, 2), 1));
                endcase
            end
            if ($urandom_range(0, 4) == 0)
                run_seq(s, 1, $urandom_range(0, NC - 1), 16'h40 + $urandom_range(0, 3),
                        $urandom_range(0, 2), 1'b1);
            else
                run_seq(s, 0, 0, 0, 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
